// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer and instruction register feeding the address decoder.
// Optional single-step gating of the fetch phase: define SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int IW  = 16,
  parameter int OPW = 8
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [IW-1:0]     ram_q,
  output logic [OPW-1:0]    IR_opcode,
  output logic [IW-OPW-1:0] IR_operand,
  output logic [3:0]        IR_oldopcode,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              EXEC3,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_EXEC3 = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] CLS_LDN = 4'b1001;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ir;
  logic [3:0]      r_oldop;
  logic            r_fetch;
  logic            r_exec1;
  logic            r_exec2;
  logic            r_exec3;
  logic            r_halted;
  logic            w_step;
  logic            w_multi;
  logic [OPW-1:0]  w_opcode;
  logic [3:0]      w_class;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif

  assign w_opcode = r_ir[IW-1:IW-OPW];
  assign w_class  = w_opcode[OPW-1 -: 4];

  // Instructions needing a second execute phase: LDA/ADD/SUB/MUL/LDN/RET classes and POP.
  always_comb begin
    w_multi = 1'b0;
    case (w_class)
      4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b1001, 4'b1111: w_multi = 1'b1;
      default: w_multi = (w_opcode == 8'hA8);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (w_step) w_next = S_EXEC1;
      S_EXEC1: begin
        if (w_opcode == 8'hA0) w_next = S_HALT;
        else if (w_multi)      w_next = S_EXEC2;
        else                   w_next = S_FETCH;
      end
      // The IR may hold an LDN pointer by now, so the saved class decides.
      S_EXEC2: w_next = (r_oldop == CLS_LDN) ? S_EXEC3 : S_FETCH;
      S_EXEC3: w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_oldop  <= '0;
      r_halted <= 1'b0;
      r_fetch  <= 1'b1;
      r_exec1  <= 1'b0;
      r_exec2  <= 1'b0;
      r_exec3  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_fetch  <= (w_next == S_FETCH);
      r_exec1  <= (w_next == S_EXEC1);
      r_exec2  <= (w_next == S_EXEC2);
      r_exec3  <= (w_next == S_EXEC3);
      r_halted <= r_halted | (w_next == S_HALT);
      case (r_state)
        S_FETCH: if (w_step) r_ir <= ram_q;
        S_EXEC1: begin
          r_oldop <= w_class;
          if (w_class == CLS_LDN) r_ir <= ram_q;
        end
        default: ;
      endcase
    end
  end

  assign IR_opcode    = w_opcode;
  assign IR_operand   = r_ir[IW-OPW-1:0];
  assign IR_oldopcode = r_oldop;
  assign FETCH        = r_fetch;
  assign EXEC1        = r_exec1;
  assign EXEC2        = r_exec2;
  assign EXEC3        = r_exec3;
  assign halted       = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry per clock.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step  = 1'b1;
  logic [15:0] ram_q = 16'h0000;
  logic [7:0]  IR_opcode;
  logic [7:0]  IR_operand;
  logic [3:0]  IR_oldopcode;
  logic        FETCH, EXEC1, EXEC2, EXEC3, halted;

  instr_sequencer dut (
    .clock        (clock),
    .reset        (reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .ram_q        (ram_q),
    .IR_opcode    (IR_opcode),
    .IR_operand   (IR_operand),
    .IR_oldopcode (IR_oldopcode),
    .FETCH        (FETCH),
    .EXEC1        (EXEC1),
    .EXEC2        (EXEC2),
    .EXEC3        (EXEC3),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [3:0]  strb;
    logic        h;
    logic [15:0] ir;
    logic [3:0]  old;
  } exp_t;

  localparam logic [3:0] SF = 4'b1000;
  localparam logic [3:0] S1 = 4'b0100;
  localparam logic [3:0] S2 = 4'b0010;
  localparam logic [3:0] S3 = 4'b0001;
  localparam logic [3:0] SH = 4'b0000;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic cyc(input string nm, input logic rst, input logic [15:0] ram,
                     input logic [3:0] strb, input logic h, input logic [15:0] ir,
                     input logic [3:0] old);
    exp_t e;
    reset = rst;
    ram_q = ram;
    e.name = nm; e.strb = strb; e.h = h; e.ir = ir; e.old = old;
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [28:0] act, req;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {FETCH, EXEC1, EXEC2, EXEC3, halted, IR_opcode, IR_operand, IR_oldopcode};
        req = {e.strb, e.h, e.ir, e.old};
        n_tests++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s: got strb=%b h=%b ir=%h old=%h, want strb=%b h=%b ir=%h old=%h",
                   e.name, act[28:25], act[24], act[23:8], act[3:0],
                   e.strb, e.h, e.ir, e.old);
        end
      end
    end
  end

  initial begin : stim
    cyc("rst0", 1, 16'h55AA, SF, 0, 16'h0000, 4'h0);
    cyc("rst1", 1, 16'h55AA, SF, 0, 16'h0000, 4'h0);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc("step_hold", 0, 16'h2222, SF, 0, 16'h0000, 4'h0);
    step = 1'b1;
`endif
    // STA: two-cycle instruction
    cyc("sta_e1",  0, 16'h1042, S1, 0, 16'h1042, 4'h0);
    cyc("sta_f",   0, 16'h0000, SF, 0, 16'h1042, 4'h1);
    // ADD: EXEC2, no EXEC3
    cyc("add_e1",  0, 16'h2007, S1, 0, 16'h2007, 4'h1);
    cyc("add_e2",  0, 16'h0000, S2, 0, 16'h2007, 4'h2);
    cyc("add_f",   0, 16'h0000, SF, 0, 16'h2007, 4'h2);
    // LDN: pointer reload in EXEC1, class held through EXEC3
    cyc("ldn_e1",  0, 16'h9010, S1, 0, 16'h9010, 4'h2);
    cyc("ldn_e2",  0, 16'h0033, S2, 0, 16'h0033, 4'h9);
    cyc("ldn_e3",  0, 16'h0000, S3, 0, 16'h0033, 4'h9);
    cyc("ldn_f",   0, 16'h0000, SF, 0, 16'h0033, 4'h9);
    // LDA interrupted by reset during EXEC2
    cyc("lda_e1",  0, 16'h0005, S1, 0, 16'h0005, 4'h9);
    cyc("lda_e2",  0, 16'h0000, S2, 0, 16'h0005, 4'h0);
    cyc("lda_rst", 1, 16'h0000, SF, 0, 16'h0000, 4'h0);
    // POP: class A but takes EXEC2, then not EXEC3
    cyc("pop_e1",  0, 16'hA8FF, S1, 0, 16'hA8FF, 4'h0);
    cyc("pop_e2",  0, 16'h0000, S2, 0, 16'hA8FF, 4'hA);
    cyc("pop_f",   0, 16'h0000, SF, 0, 16'hA8FF, 4'hA);
    // Undefined SSS sub-code is single-cycle
    cyc("a1_e1",   0, 16'hA1CC, S1, 0, 16'hA1CC, 4'hA);
    cyc("a1_f",    0, 16'h0000, SF, 0, 16'hA1CC, 4'hA);
    // STP: absorbing halt
    cyc("stp_e1",  0, 16'hA000, S1, 0, 16'hA000, 4'hA);
    for (int i = 0; i < 11; i++)
      cyc("halt", 0, 16'h9123, SH, 1, 16'hA000, 4'hA);
    cyc("halt_rst", 1, 16'h1234, SF, 0, 16'h0000, 4'h0);
    // SUB, jump-class, RET, MUL
    cyc("sub_e1",  0, 16'h3005, S1, 0, 16'h3005, 4'h0);
    cyc("sub_e2",  0, 16'h0000, S2, 0, 16'h3005, 4'h3);
    cyc("sub_f",   0, 16'h0000, SF, 0, 16'h3005, 4'h3);
    cyc("jmp_e1",  0, 16'h5011, S1, 0, 16'h5011, 4'h3);
    cyc("jmp_f",   0, 16'h0000, SF, 0, 16'h5011, 4'h5);
    cyc("ret_e1",  0, 16'hF001, S1, 0, 16'hF001, 4'h5);
    cyc("ret_e2",  0, 16'h0000, S2, 0, 16'hF001, 4'hF);
    cyc("ret_f",   0, 16'h0000, SF, 0, 16'hF001, 4'hF);
    cyc("mul_e1",  0, 16'h4102, S1, 0, 16'h4102, 4'hF);
    cyc("mul_e2",  0, 16'h0000, S2, 0, 16'h4102, 4'h4);
    cyc("mul_f",   0, 16'h0000, SF, 0, 16'h4102, 4'h4);
    repeat (3) @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
